// File: rtl/chip8_keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_keypad_pkg                                                           |
// | Shared keypad constants, key vector type and priority-encode helper.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package chip8_keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef logic [15:0] key_vec_t;

  // Entry r*4+c is the CHIP-8 value of the key at row r, column c.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] lowest_set(input key_vec_t v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip8_keypad_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_keypad_sync                                                          |
// | Two-flop synchroniser for the asynchronous active-low row inputs.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chip8_keypad_sync
  import chip8_keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_ROWS-1:0] row_o
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  // Reset to all-ones: the idle level of the pulled-up rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/chip8_keypad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chip8_keypad                                                               |
// | 4x4 matrix scanner with debounce; optional new-key event output built      |
// | when CHIP8_KEYPAD_EVENT_EN is defined.                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chip8_keypad
  import chip8_keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_COLS-1:0] col_out,
  input  logic [NUM_ROWS-1:0] row_in,
  output key_vec_t            keys,
  output logic                key_event,
  output logic [3:0]          key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] rows_s;
  logic [1:0]          col_q;
  logic [DIV_W-1:0]    div_q;
  logic [STB_W-1:0]    stable_q;
  logic [STB_W-1:0]    stable_inc;
  key_vec_t            raw_q;
  key_vec_t            raw_d;
  key_vec_t            scan_d;
  key_vec_t            cand_q;
  key_vec_t            keys_q;
  logic                sample;
  logic                scan_end;
  logic                keys_load;

  chip8_keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .row_i (row_in),
    .row_o (rows_s)
  );

  // raw_d folds the current column's sample into the physical-order image so
  // the column-3 sample takes part in the end-of-scan compare on the same edge.
  always_comb begin
    raw_d = raw_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (2'(c) == col_q) raw_d[r*NUM_COLS + c] = ~rows_s[r];
      end
    end
    scan_d = '0;
    for (int p = 0; p < 16; p++) begin
      scan_d[KEY_MAP[p]] = raw_d[p];
    end
  end

  assign sample     = (div_q == DIV_LAST);
  assign scan_end   = sample && (col_q == 2'd3);
  assign stable_inc = stable_q + STB_W'(1);
  assign keys_load  = scan_end && (scan_d == cand_q) && (stable_q < STB_MAX)
                      && (stable_inc == STB_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      div_q    <= '0;
      raw_q    <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      keys_q   <= '0;
    end else begin
      if (sample) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        raw_q <= raw_d;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (scan_end) begin
        if (scan_d != cand_q) begin
          cand_q   <= scan_d;
          stable_q <= STB_W'(1);
        end else if (stable_q < STB_MAX) begin
          stable_q <= stable_inc;
        end
      end
      if (keys_load) keys_q <= scan_d;
    end
  end

  assign col_out = ~(4'b0001 << col_q);
  assign keys    = keys_q;

`ifdef CHIP8_KEYPAD_EVENT_EN
  key_vec_t   new_set;
  logic       event_q;
  logic [3:0] code_q;

  assign new_set = scan_d & ~keys_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      event_q <= keys_load && (|new_set);
      if (keys_load && (|new_set)) code_q <= lowest_set(new_set);
    end
  end

  assign key_event = event_q;
  assign key_code  = code_q;
`else
  assign key_event = 1'b0;
  assign key_code  = 4'h0;
`endif

endmodule
`default_nettype wire
